// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the boot-time config link: register map, loader states,
// processor geometry presets and the write record carried over the link.
package bp_cfg_link_pkg;

    typedef enum logic [15:0] {
        e_cfg_freeze      = 16'h0001,
        e_cfg_core_id     = 16'h0002,
        e_cfg_cord        = 16'h0003,
        e_cfg_icache_mode = 16'h0004,
        e_cfg_dcache_mode = 16'h0005,
        e_cfg_npc         = 16'h0006
    } bp_cfg_reg_e;

    typedef enum logic [1:0] {
        e_ld_idle     = 2'd0,
        e_ld_config   = 2'd1,
        e_ld_unfreeze = 2'd2,
        e_ld_done     = 2'd3
    } bp_cfg_loader_state_e;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg = 2'd0,
        e_bp_dual_core_cfg   = 2'd1,
        e_bp_quad_core_cfg   = 2'd2,
        e_bp_oct_core_cfg    = 2'd3
    } bp_params_e;

    typedef struct packed {
        int cc_x_dim;
        int cc_y_dim;
        int ioc_y_dim;
        int paddr_width;
    } bp_proc_param_s;

    typedef struct packed {
        logic [7:0]  dst;
        logic [15:0] addr;
        logic [63:0] data;
    } bp_cfg_write_s;

    localparam int cfg_regs_per_core_gp = 6;

    function automatic bp_proc_param_s bp_get_proc_params(input bp_params_e cfg);
        bp_proc_param_s p;
        p.ioc_y_dim   = 1;
        p.paddr_width = 40;
        case (cfg)
            e_bp_dual_core_cfg: begin p.cc_x_dim = 2; p.cc_y_dim = 1; end
            e_bp_quad_core_cfg: begin p.cc_x_dim = 2; p.cc_y_dim = 2; end
            e_bp_oct_core_cfg:  begin p.cc_x_dim = 4; p.cc_y_dim = 2; end
            default:            begin p.cc_x_dim = 1; p.cc_y_dim = 1; end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bp_cfg_boot_loader_if.sv
// Valid/ready config-write link from the boot loader to the tile config ports.
interface bp_cfg_boot_loader_if #(
    parameter int dst_width_p  = 1,
    parameter int addr_width_p = 16,
    parameter int data_width_p = 64
);
    logic                    cfg_v;
    logic                    cfg_ready;
    logic [dst_width_p-1:0]  cfg_dst;
    logic [addr_width_p-1:0] cfg_addr;
    logic [data_width_p-1:0] cfg_data;

    modport master (output cfg_v, cfg_dst, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_v, cfg_dst, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/bp_cfg_boot_rom.sv
// Combinational table mapping (register index, core index) to the config write
// address and zero-extended data; the unfreeze pass always writes freeze=0.
module bp_cfg_boot_rom import bp_cfg_link_pkg::*; #(
    parameter int                  cc_x_dim_p    = 1,
    parameter int                  ioc_y_dim_p   = 1,
    parameter int                  core_width_p  = 1,
    parameter int                  addr_width_p  = 16,
    parameter int                  data_width_p  = 64,
    parameter int                  pc_width_p    = 40,
    parameter logic [pc_width_p-1:0] boot_pc_p   = '0,
    parameter int                  icache_mode_p = 1,
    parameter int                  dcache_mode_p = 1
) (
    input  logic                    unfreeze_i,
    input  logic [2:0]              reg_idx_i,
    input  logic [core_width_p-1:0] core_idx_i,
    output logic [addr_width_p-1:0] addr_o,
    output logic [data_width_p-1:0] data_o
);

    logic [31:0] core_full;
    logic [15:0] cord;

    // Tiles sit above the I/O complex rows, hence the y offset.
    assign core_full = 32'(core_idx_i);
    assign cord      = {8'(core_full / 32'(cc_x_dim_p) + 32'(ioc_y_dim_p)),
                        8'(core_full % 32'(cc_x_dim_p))};

    always_comb begin
        addr_o = '0;
        data_o = '0;
        if (unfreeze_i) begin
            addr_o = addr_width_p'(e_cfg_freeze);
        end else begin
            case (reg_idx_i)
                3'd0: begin
                    addr_o = addr_width_p'(e_cfg_freeze);
                    data_o = data_width_p'(1);
                end
                3'd1: begin
                    addr_o = addr_width_p'(e_cfg_core_id);
                    data_o = data_width_p'(core_idx_i);
                end
                3'd2: begin
                    addr_o = addr_width_p'(e_cfg_cord);
                    data_o = data_width_p'(cord);
                end
                3'd3: begin
                    addr_o = addr_width_p'(e_cfg_icache_mode);
                    data_o = data_width_p'(icache_mode_p);
                end
                3'd4: begin
                    addr_o = addr_width_p'(e_cfg_dcache_mode);
                    data_o = data_width_p'(dcache_mode_p);
                end
                3'd5: begin
                    addr_o = addr_width_p'(e_cfg_npc);
                    data_o = data_width_p'(boot_pc_p);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bp_cfg_boot_loader.sv
// Boot-time config sequencer: configures every core over the cfg link, then
// releases all cores from freeze and parks in DONE until reset.
module bp_cfg_boot_loader import bp_cfg_link_pkg::*; #(
    parameter bp_params_e  bp_params_p      = e_bp_single_core_cfg,
    parameter int          cfg_addr_width_p = 16,
    parameter int          cfg_data_width_p = 64,
    parameter logic [39:0] boot_pc_p        = 40'h00_8000_0000,
    parameter int          icache_mode_p    = 1,
    parameter int          dcache_mode_p    = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    bp_cfg_boot_loader_if.master cfg_if,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam bp_proc_param_s proc_lp = bp_get_proc_params(bp_params_p);
    localparam int num_core_lp   = proc_lp.cc_x_dim * proc_lp.cc_y_dim;
    localparam int core_width_lp = (num_core_lp > 1) ? $clog2(num_core_lp) : 1;

    if (cfg_data_width_p < proc_lp.paddr_width || cfg_data_width_p < $bits(boot_pc_p) ||
        cfg_data_width_p < 16 || cfg_data_width_p < core_width_lp) begin : g_bad_data_width
        $error("cfg_data_width_p too narrow for config fields");
    end
    if (cfg_addr_width_p < 16) begin : g_bad_addr_width
        $error("cfg_addr_width_p too narrow for config register map");
    end

    bp_cfg_loader_state_e        state_q, state_d;
    logic [core_width_lp-1:0]    core_idx_q, core_idx_d;
    logic [2:0]                  reg_idx_q, reg_idx_d;
    logic                        v_q, v_d, done_q;
    logic [core_width_lp-1:0]    dst_q;
    logic [cfg_addr_width_p-1:0] addr_q, rom_addr;
    logic [cfg_data_width_p-1:0] data_q, rom_data;
    logic                        fire, last_core, last_reg;

    assign fire      = v_q & cfg_if.cfg_ready;
    assign last_core = (core_idx_q == core_width_lp'(num_core_lp - 1));
    assign last_reg  = (reg_idx_q == 3'(cfg_regs_per_core_gp - 1));

    always_comb begin
        state_d    = state_q;
        core_idx_d = core_idx_q;
        reg_idx_d  = reg_idx_q;
        unique case (state_q)
            e_ld_idle: begin
                if (start_i) begin
                    state_d    = e_ld_config;
                    core_idx_d = '0;
                    reg_idx_d  = '0;
                end
            end
            e_ld_config: begin
                if (fire) begin
                    if (last_reg) begin
                        reg_idx_d = '0;
                        if (last_core) begin
                            state_d    = e_ld_unfreeze;
                            core_idx_d = '0;
                        end else begin
                            core_idx_d = core_idx_q + core_width_lp'(1);
                        end
                    end else begin
                        reg_idx_d = reg_idx_q + 3'd1;
                    end
                end
            end
            e_ld_unfreeze: begin
                if (fire) begin
                    if (last_core) begin
                        state_d    = e_ld_done;
                        core_idx_d = '0;
                    end else begin
                        core_idx_d = core_idx_q + core_width_lp'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered from next-state so a new write appears the cycle after a fire.
    assign v_d = (state_d == e_ld_config) || (state_d == e_ld_unfreeze);

    bp_cfg_boot_rom #(
        .cc_x_dim_p    (proc_lp.cc_x_dim),
        .ioc_y_dim_p   (proc_lp.ioc_y_dim),
        .core_width_p  (core_width_lp),
        .addr_width_p  (cfg_addr_width_p),
        .data_width_p  (cfg_data_width_p),
        .pc_width_p    ($bits(boot_pc_p)),
        .boot_pc_p     (boot_pc_p),
        .icache_mode_p (icache_mode_p),
        .dcache_mode_p (dcache_mode_p)
    ) u_rom (
        .unfreeze_i (state_d == e_ld_unfreeze),
        .reg_idx_i  (reg_idx_d),
        .core_idx_i (core_idx_d),
        .addr_o     (rom_addr),
        .data_o     (rom_data)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_ld_idle;
            core_idx_q <= '0;
            reg_idx_q  <= '0;
            v_q        <= 1'b0;
            done_q     <= 1'b0;
            dst_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            core_idx_q <= core_idx_d;
            reg_idx_q  <= reg_idx_d;
            v_q        <= v_d;
            done_q     <= (state_d == e_ld_done);
            dst_q      <= v_d ? core_idx_d : '0;
            addr_q     <= v_d ? rom_addr   : '0;
            data_q     <= v_d ? rom_data   : '0;
        end
    end

    assign cfg_if.cfg_v    = v_q;
    assign cfg_if.cfg_dst  = dst_q;
    assign cfg_if.cfg_addr = addr_q;
    assign cfg_if.cfg_data = data_q;
    assign busy_o          = v_q;
    assign done_o          = done_q;

endmodule
